icache_tag_array: RTL and testbench
===================================

# icache_tag_array

Parametrised N-way tag store for the instruction cache, the successor to the single-way 256×20 tag RAM. Each way holds a valid bit and tag per set. The block adds:
- registered hit compare with a one-hot hit way;
- victim selection on refill;
- single-set invalidate;
- a whole-array flush sequencer that also runs automatically out of reset.

It sits between the icache lookup pipeline and the refill controller; data RAMs are indexed using `hit_way_o` and `fill_way_o`.

## Interface
- `WAYS`, 2: associativity, 1..8.
- `SETS`, 256: sets per way, power of two ≥ 2.
- `TAG_W`, 20: tag width in bits.
- `IDX_W`, `$clog2(SETS)`: set index width, derived; do not override.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `lookup_req_i`  in  1  lookup strobe.
- `lookup_idx_i`  in  IDX_W  set index to look up.
- `lookup_tag_i`  in  TAG_W  tag to compare.
- `hit_o`  out  1  lookup hit, valid the cycle after the request.
- `hit_way_o`  out  WAYS  one-hot hit way, 0 on miss.
- `fill_i`  in  1  refill request.
- `fill_idx_i`  in  IDX_W  set index for refill.
- `fill_tag_i`  in  TAG_W  tag to install.
- `fill_way_o`  out  WAYS  one-hot way written by the current fill; valid while `fill_done_o`=1.
- `fill_done_o`  out  1  one-cycle pulse when the fill write occurs.
- `inval_i`  in  1  invalidate all ways of one set.
- `inval_idx_i`  in  IDX_W  set index to invalidate.
- `flush_i`  in  1  invalidate the entire array.
- `busy_o`  out  1  block is flushing or finishing a fill; new requests are ignored.
- `parity_err_o`  out  1  parity error detected on a lookup (see Configuration).

## Operation
- Storage: WAYS single-port read-first RAMs, each SETS × (1 valid + TAG_W [+1 parity]).
- Valid bits live in the RAM and are not reset, so correctness depends on the flush sequencer.

State machine (`state_q`), states FLUSH, IDLE, FILL:
- **FLUSH.** Entered on `rst` or on `flush_i` in IDLE.
  - `flush_idx_q` counts 0..SETS-1; one set per cycle is written with valid=0 in all ways.
  - After writing set SETS-1, go to IDLE; the counter wraps to 0.
  - `busy_o`=1 throughout.
  - `rst` asserted mid-flush restarts the flush at index 0.
- **IDLE.** Accepts requests. Priority: `flush_i` > `inval_i` > `fill_i`; lower-priority requests in the same cycle are dropped.
  - **Invalidate** is a single-cycle write of valid=0 to all ways of `inval_idx_i`, with no state change.
  - **Fill** reads set `fill_idx_i`, latches the index and tag, and goes to FILL.
- **FILL.** One cycle.
  - Victim: the lowest-numbered invalid way from the read data. If all ways are valid, the way selected by the round-robin pointer `rr_q`.
  - Write {1, tag} to the victim, pulse `fill_done_o`, drive `fill_way_o`, return to IDLE.
  - `rr_q` advances by one (mod WAYS) only when a valid way is replaced.
  - If WAYS=1, the victim is always way 0.
- **Lookup.** Accepted in IDLE only; in FLUSH or FILL, `lookup_req_i` yields `hit_o`=0.
  - The RAM read and the registered request, tag and index produce the compare in the next cycle.
  - Hit when valid=1 and the stored tag equals the registered tag.
  - If several ways hit (corruption), `hit_way_o` reports the lowest way only.
- **Port arbitration.**
  - A lookup shares the RAM port with invalidate and fill-read in IDLE. Lookup and fill-read use the same read; if both are requested, `fill_idx_i` must equal `lookup_idx_i`, otherwise the lookup returns a miss.
  - Invalidate plus lookup in the same cycle: the lookup sees the pre-invalidate contents (read-first).

## Timing
- Reset values: `hit_o`=0, `hit_way_o`=0, `fill_way_o`=0, `fill_done_o`=0, `parity_err_o`=0, `busy_o`=1, `rr_q`=0, `flush_idx_q`=0, `state_q`=FLUSH.
- Flush: `busy_o` falls SETS cycles after reset deasserts or after `flush_i` is accepted; the first lookup is accepted the cycle `busy_o`=0.
- Lookup latency: 1 cycle, request in cycle N, `hit_o` in N+1. Back-to-back lookups every cycle are supported.
- Fill latency: request in N, write and `fill_done_o` in N+1, `busy_o`=1 in N+1. A lookup of the filled tag issued in N+2 hits.
- Invalidate: takes effect for lookups issued in N+1 onward.

## Configuration
- `ICACHE_TAG_PARITY_EN` defined:
  - Each entry stores an even-parity bit over {valid, tag}.
  - A parity mismatch on a lookup forces that way to miss and pulses `parity_err_o` in the result cycle.
  - Fill and flush write correct parity.
- Macro undefined: no parity bit is stored and `parity_err_o` is tied to 0.

## Structure
- Shared `icache_pkg`/defines header:
  - state encodings (FLUSH=0, IDLE=1, FILL=2);
  - default `WAYS`, `SETS`, `TAG_W`;
  - the entry width macro (TAG_W+1, plus 1 with parity).
- Sub-module `icache_tag_way`: a parametrised single-port read-first RAM, depth SETS, width set by the entry width macro, instantiated WAYS times. Compare, victim select and FSM live in the top level.

## Test plan
- Reset, then hold `rst` 3 cycles: `busy_o`=1 for exactly 256 cycles after release; a lookup of idx 0x00, tag 0 returns `hit_o`=0.
- Fill idx 0x12, tag 0xABCDE: `fill_done_o` pulses one cycle later with `fill_way_o`=2'b01. A lookup of 0x12/0xABCDE then gives `hit_o`=1, `hit_way_o`=2'b01; a lookup with tag 0xABCDF misses.
- Three fills to idx 0x12 with tags A, B, C (WAYS=2): A→way0, B→way1, C replaces way0 (`rr_q`=0→1); tag A then misses and tags B and C hit.
- `inval_i` idx 0x12 in the same cycle as a lookup of 0x12/B: that lookup hits; the next lookup of 0x12/B misses.
- `flush_i` mid-run, with `fill_i` in the same cycle: the fill is dropped, `busy_o` is high for 256 cycles, and all prior tags miss afterwards.
- With `ICACHE_TAG_PARITY_EN`: corrupt one tag bit of way1, idx 0x05 via backdoor; a lookup of that tag gives `hit_o`=0 and `parity_err_o`=1 for one cycle.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared state encoding, default geometry and entry-width macro for the icache tag store.
// ICACHE_TAG_PARITY_EN widens every entry by one even-parity bit.
`ifndef ICACHE_PKG_SV
`define ICACHE_PKG_SV

`ifdef ICACHE_TAG_PARITY_EN
`define ICACHE_ENTRY_W(tw) ((tw) + 2)
`else
`define ICACHE_ENTRY_W(tw) ((tw) + 1)
`endif

package icache_pkg;
  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FILL  = 2'd2
  } state_e;

  localparam int DEF_WAYS  = 2;
  localparam int DEF_SETS  = 256;
  localparam int DEF_TAG_W = 20;
endpackage

`endif

// File: rtl/icache_tag_way.sv
// Single-port read-first RAM holding one way of the tag store.
// Contents are not reset; the parent flush sequencer initialises them.
module icache_tag_way #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 21,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (we) mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/icache_tag_array.sv
// N-way icache tag store: lookup compare, victim select, set invalidate and flush sequencer.
// Optional per-entry parity is enabled with ICACHE_TAG_PARITY_EN.
//
// state    | meaning
// ST_FLUSH | writing valid=0 to one set per cycle, busy
// ST_IDLE  | accepting lookup / invalidate / fill / flush
// ST_FILL  | writing the latched tag into the chosen victim way, busy
module icache_tag_array
  import icache_pkg::*;
#(
  parameter int WAYS  = DEF_WAYS,
  parameter int SETS  = DEF_SETS,
  parameter int TAG_W = DEF_TAG_W,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lookup_req_i,
  input  logic [IDX_W-1:0] lookup_idx_i,
  input  logic [TAG_W-1:0] lookup_tag_i,
  output logic             hit_o,
  output logic [WAYS-1:0]  hit_way_o,
  input  logic             fill_i,
  input  logic [IDX_W-1:0] fill_idx_i,
  input  logic [TAG_W-1:0] fill_tag_i,
  output logic [WAYS-1:0]  fill_way_o,
  output logic             fill_done_o,
  input  logic             inval_i,
  input  logic [IDX_W-1:0] inval_idx_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             parity_err_o
);

  localparam int ENTRY_W = `ICACHE_ENTRY_W(TAG_W);
  localparam int RR_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] flush_idx_q, fill_idx_q;
  logic [TAG_W-1:0] fill_tag_q, lk_tag_q;
  logic             lk_v_q;
  logic [RR_W-1:0]  rr_q;

  logic               ram_en;
  logic [WAYS-1:0]    ram_we;
  logic [IDX_W-1:0]   ram_addr;
  logic [ENTRY_W-1:0] ram_wdata;
  logic [ENTRY_W-1:0] ram_rdata [WAYS];

  logic            idle, do_flush, do_inval, do_fill, lk_go;
  logic [WAYS-1:0] way_valid, hit_vec, perr_vec, victim_oh;
  logic [RR_W-1:0] victim;
  logic            victim_free;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic v, input logic [TAG_W-1:0] t);
`ifdef ICACHE_TAG_PARITY_EN
    return {^{v, t}, v, t};
`else
    return {v, t};
`endif
  endfunction

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_tag_way #(.DEPTH(SETS), .WIDTH(ENTRY_W)) u_way (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we[w]),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata[w])
    );
    assign way_valid[w] = ram_rdata[w][TAG_W];
`ifdef ICACHE_TAG_PARITY_EN
    assign perr_vec[w] = lk_v_q & (^ram_rdata[w]);
`else
    assign perr_vec[w] = 1'b0;
`endif
    assign hit_vec[w] = lk_v_q & way_valid[w] & ~perr_vec[w]
                        & (ram_rdata[w][TAG_W-1:0] == lk_tag_q);
  end

  assign idle     = (state_q == ST_IDLE);
  assign do_flush = idle & flush_i;
  assign do_inval = idle & ~flush_i & inval_i;
  assign do_fill  = idle & ~flush_i & ~inval_i & fill_i;
  // The lookup rides on whatever read the port performs this cycle, so it must target the same set.
  assign lk_go    = idle & lookup_req_i
                    & (~do_inval | (inval_idx_i == lookup_idx_i))
                    & (~do_fill | (fill_idx_i == lookup_idx_i));

  always_comb begin
    victim      = rr_q;
    victim_free = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) begin
        victim      = RR_W'(w);
        victim_free = 1'b1;
      end
    end
  end

  assign victim_oh = WAYS'(1) << victim;

  always_comb begin
    state_d   = state_q;
    ram_en    = 1'b0;
    ram_we    = '0;
    ram_addr  = lookup_idx_i;
    ram_wdata = make_entry(1'b0, '0);
    unique case (state_q)
      ST_FLUSH: begin
        ram_en   = 1'b1;
        ram_we   = '1;
        ram_addr = flush_idx_q;
        if (flush_idx_q == IDX_W'(SETS - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (do_flush) begin
          state_d = ST_FLUSH;
        end else if (do_inval) begin
          ram_en   = 1'b1;
          ram_we   = '1;
          ram_addr = inval_idx_i;
        end else if (do_fill) begin
          ram_en   = 1'b1;
          ram_addr = fill_idx_i;
          state_d  = ST_FILL;
        end
        if (lk_go) ram_en = 1'b1;
      end
      ST_FILL: begin
        ram_en    = 1'b1;
        ram_we    = victim_oh;
        ram_addr  = fill_idx_q;
        ram_wdata = make_entry(1'b1, fill_tag_q);
        state_d   = ST_IDLE;
      end
      default: state_d = ST_FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FLUSH;
      flush_idx_q <= '0;
      rr_q        <= '0;
      lk_v_q      <= 1'b0;
      lk_tag_q    <= '0;
      fill_idx_q  <= '0;
      fill_tag_q  <= '0;
    end else begin
      state_q <= state_d;
      lk_v_q  <= lk_go;
      if (lk_go) lk_tag_q <= lookup_tag_i;
      if (state_q == ST_FLUSH) flush_idx_q <= flush_idx_q + 1'b1;
      if (do_fill) begin
        fill_idx_q <= fill_idx_i;
        fill_tag_q <= fill_tag_i;
      end
      if (state_q == ST_FILL && !victim_free)
        rr_q <= (rr_q == RR_W'(WAYS - 1)) ? '0 : rr_q + 1'b1;
    end
  end

  assign hit_o        = |hit_vec;
  assign hit_way_o    = hit_vec & (~hit_vec + WAYS'(1));
  assign fill_done_o  = (state_q == ST_FILL);
  assign fill_way_o   = fill_done_o ? victim_oh : '0;
  assign busy_o       = ~idle;
  assign parity_err_o = |perr_vec;

endmodule

// File: tb/tb_icache_tag_array.sv
// Scoreboard bench for icache_tag_array: a set/way array model predicts lookup and fill results.
// Build with ICACHE_TAG_PARITY_EN to add the backdoor parity-corruption scenario.
module tb_icache_tag_array;
  localparam int WAYS  = 2;
  localparam int SETS  = 256;
  localparam int TAG_W = 20;
  localparam int IDX_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             lookup_req_i = 1'b0;
  logic [IDX_W-1:0] lookup_idx_i = '0;
  logic [TAG_W-1:0] lookup_tag_i = '0;
  logic             hit_o;
  logic [WAYS-1:0]  hit_way_o;
  logic             fill_i = 1'b0;
  logic [IDX_W-1:0] fill_idx_i = '0;
  logic [TAG_W-1:0] fill_tag_i = '0;
  logic [WAYS-1:0]  fill_way_o;
  logic             fill_done_o;
  logic             inval_i = 1'b0;
  logic [IDX_W-1:0] inval_idx_i = '0;
  logic             flush_i = 1'b0;
  logic             busy_o;
  logic             parity_err_o;

  icache_tag_array #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .lookup_req_i(lookup_req_i), .lookup_idx_i(lookup_idx_i), .lookup_tag_i(lookup_tag_i),
    .hit_o(hit_o), .hit_way_o(hit_way_o),
    .fill_i(fill_i), .fill_idx_i(fill_idx_i), .fill_tag_i(fill_tag_i),
    .fill_way_o(fill_way_o), .fill_done_o(fill_done_o),
    .inval_i(inval_i), .inval_idx_i(inval_idx_i), .flush_i(flush_i),
    .busy_o(busy_o), .parity_err_o(parity_err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            hit;
    logic [WAYS-1:0] way;
    logic            perr;
  } lk_exp_t;

  lk_exp_t         lkq[$];
  logic [WAYS-1:0] fq[$];
  int errors = 0;
  int checks = 0;

  // Reference model: per-way valid/tag arrays, corruption marks, round-robin pointer, busy window.
  bit               mv [WAYS][SETS];
  logic [TAG_W-1:0] mt [WAYS][SETS];
  bit               mc [WAYS][SETS];
  int               rr = 0;
  int               busy_left = SETS;

  bit lk_issue = 0, fill_issue = 0;
  bit lk_seen = 0, fill_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++) begin
        mv[w][s] = 0;
        mc[w][s] = 0;
      end
  endtask

  task automatic step(input bit r, input bit lk, input int li, input int lt,
                      input bit fl, input int fi, input int ft,
                      input bit iv, input int ii, input bit fu);
    bit      idle, port_ok;
    lk_exp_t e;
    int      v;
    @(posedge clk);
    #1;
    chk("busy", busy_o, 32'(busy_left != 0));
    rst = r;
    lookup_req_i = lk; lookup_idx_i = IDX_W'(li); lookup_tag_i = TAG_W'(lt);
    fill_i = fl; fill_idx_i = IDX_W'(fi); fill_tag_i = TAG_W'(ft);
    inval_i = iv; inval_idx_i = IDX_W'(ii); flush_i = fu;
    idle = (busy_left == 0) && !r;
    lk_issue = lk;
    fill_issue = 0;
    if (lk) begin
      e = '0;
      port_ok = 1;
      if (!fu && iv && ii != li) port_ok = 0;
      if (!fu && !iv && fl && fi != li) port_ok = 0;
      if (idle && port_ok) begin
        for (int w = 0; w < WAYS; w++) begin
          if (mc[w][li]) e.perr = 1;
          else if (mv[w][li] && mt[w][li] == TAG_W'(lt) && e.way == 0) e.way = WAYS'(1) << w;
        end
        e.hit = (e.way != 0);
      end
      lkq.push_back(e);
    end
    if (r) begin
      busy_left = SETS;
      rr = 0;
      clear_model();
    end else if (!idle) begin
      busy_left--;
    end else if (fu) begin
      busy_left = SETS;
      clear_model();
    end else if (iv) begin
      for (int w = 0; w < WAYS; w++) begin
        mv[w][ii] = 0;
        mc[w][ii] = 0;
      end
    end else if (fl) begin
      v = -1;
      for (int w = 0; w < WAYS; w++) if (!mv[w][fi] && v < 0) v = w;
      if (v < 0) begin
        v = rr;
        rr = (rr + 1) % WAYS;
      end
      mv[v][fi] = 1;
      mt[v][fi] = TAG_W'(ft);
      mc[v][fi] = 0;
      fq.push_back(WAYS'(1) << v);
      fill_issue = 1;
      busy_left = 1;
    end
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic lookup(input int i, input int t);
    step(0, 1, i, t, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic fill(input int i, input int t);
    step(0, 0, 0, 0, 1, i, t, 0, 0, 0);
  endtask

  always @(posedge clk) begin
    lk_seen   <= lk_issue;
    fill_seen <= fill_issue;
  end

  always @(negedge clk) begin
    lk_exp_t         e;
    logic [WAYS-1:0] f;
    if (lk_seen) begin
      if (lkq.size() == 0) chk("lk_queue_underflow", 1, 0);
      else begin
        e = lkq.pop_front();
        chk("hit", hit_o, e.hit);
        chk("hit_way", hit_way_o, e.way);
        chk("parity_err", parity_err_o, e.perr);
      end
    end else begin
      chk("hit_idle", hit_o, 0);
    end
    if (fill_seen) begin
      if (fq.size() == 0) chk("fill_queue_underflow", 1, 0);
      else begin
        f = fq.pop_front();
        chk("fill_done", fill_done_o, 1);
        chk("fill_way", fill_way_o, f);
      end
    end else begin
      chk("fill_done_idle", fill_done_o, 0);
      chk("fill_way_idle", fill_way_o, 0);
    end
  end

  localparam int TA = 20'hABCDE, TA2 = 20'hABCDF, TB = 20'h12345, TC = 20'h0F0F0;

  initial begin
    int li, fi;
    bit lk, fl, iv, fu;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_hit", hit_o, 0);
    chk("rst_hit_way", hit_way_o, 0);
    chk("rst_fill_way", fill_way_o, 0);
    chk("rst_fill_done", fill_done_o, 0);
    chk("rst_parity", parity_err_o, 0);
    // Lookups during the initial flush must miss; busy is checked every step.
    lookup(0, 0);
    for (int i = 1; i < SETS; i++) nop();
    lookup(0, 0);

    fill(8'h12, TA);
    lookup(8'h12, TA);
    lookup(8'h12, TA);
    lookup(8'h12, TA2);
    fill(8'h12, TB);
    nop();
    fill(8'h12, TC);
    nop();
    lookup(8'h12, TA);
    lookup(8'h12, TB);
    lookup(8'h12, TC);

    step(0, 1, 8'h12, TB, 0, 0, 0, 1, 8'h12, 0);
    lookup(8'h12, TB);
    lookup(8'h12, TC);

    fill(8'h20, TA);
    nop();
    lookup(8'h20, TA);
    step(0, 0, 0, 0, 1, 8'h21, TB, 0, 0, 1);
    for (int i = 0; i < SETS; i++) nop();
    lookup(8'h20, TA);
    lookup(8'h21, TB);

    fill(8'h30, TC);
    nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 100; i++) nop();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < SETS; i++) nop();
    lookup(8'h30, TC);

`ifdef ICACHE_TAG_PARITY_EN
    fill(5, TA);
    nop();
    fill(5, TB);
    nop();
    nop();
    dut.g_way[1].u_way.mem[5][0] = ~dut.g_way[1].u_way.mem[5][0];
    mc[1][5] = 1;
    lookup(5, TB);
    lookup(5, TA);
    lookup(6, TA);
    step(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
    lookup(5, TA);
`endif

    for (int n = 0; n < 700; n++) begin
      lk = ($urandom_range(0, 99) < 70);
      fl = ($urandom_range(0, 99) < 25);
      iv = ($urandom_range(0, 99) < 5);
      fu = ($urandom_range(0, 249) == 0);
      li = $urandom_range(0, 3);
      fi = $urandom_range(0, 1) ? li : $urandom_range(0, 3);
      step(0, lk, li, $urandom_range(0, 5), fl, fi, $urandom_range(0, 5), iv, li, fu);
    end

    for (int i = 0; i < 3; i++) nop();
    @(negedge clk);
    @(negedge clk);
    chk("lk_queue_drained", lkq.size(), 0);
    chk("fill_queue_drained", fq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
